// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Qualifies the PLL lock flag in the clk48 domain, holds PLL-domain
//            logic in reset until lock has been stable for LOCK_CYCLES, counts
//            lock losses and drives the RGB status LED.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 4800,
    parameter int LOSS_CNT_W  = 8,
    parameter int BLINK_DIV   = 24
) (
    input  logic                  clk48,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  clear_count,
    output logic                  domain_rst,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic                  rgb_led0_r,
    output logic                  rgb_led0_g,
    output logic                  rgb_led0_b
);

    localparam int c_STAB_W = $clog2(LOCK_CYCLES);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_locked_s;
    logic [c_STAB_W-1:0]     r_stab_cnt;
    logic [c_STAB_W-1:0]     w_stab_nxt;
    logic                    w_loss_evt;
    logic                    r_lock_lost;
    logic [LOSS_CNT_W-1:0]   r_loss_count;
    logic [LOSS_CNT_W-1:0]   w_loss_nxt;
    logic [BLINK_DIV-1:0]    r_blink;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk48) begin
        if (rst) begin
            r_sync       <= '0;
            r_state      <= ST_UNLOCKED;
            r_stab_cnt   <= '0;
            r_lock_lost  <= 1'b0;
            r_loss_count <= '0;
            r_blink      <= '0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], locked};
            r_state      <= w_state_nxt;
            r_stab_cnt   <= w_stab_nxt;
            r_lock_lost  <= w_loss_evt;
            r_loss_count <= w_loss_nxt;
            r_blink      <= r_blink + BLINK_DIV'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab_cnt;
        w_loss_evt  = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_STABILIZE;
                    w_stab_nxt  = '0;
                end
            end
            ST_STABILIZE: begin
                // A drop here only restarts qualification; it is not a loss.
                if (!w_locked_s) begin
                    w_state_nxt = ST_UNLOCKED;
                end else if (r_stab_cnt == c_STAB_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_stab_nxt = r_stab_cnt + c_STAB_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_loss_evt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
            end
        endcase
    end

    // Clear wins over the old value but still records a coincident loss.
    always_comb begin
        w_loss_nxt = r_loss_count;
        if (clear_count) begin
            w_loss_nxt = w_loss_evt ? LOSS_CNT_W'(1) : '0;
        end else if (w_loss_evt && !(&r_loss_count)) begin
            w_loss_nxt = r_loss_count + LOSS_CNT_W'(1);
        end
    end

    assign domain_rst = (r_state != ST_RUN);
    assign ready      = (r_state == ST_RUN);
    assign lock_lost  = r_lock_lost;
    assign loss_count = r_loss_count;

    always_comb begin
        rgb_led0_r = 1'b1;
        rgb_led0_g = 1'b1;
        rgb_led0_b = 1'b1;
        case (r_state)
            ST_UNLOCKED:  rgb_led0_r = ~r_blink[BLINK_DIV-1];
            ST_STABILIZE: rgb_led0_b = 1'b0;
            ST_RUN:       rgb_led0_g = 1'b0;
            default:      rgb_led0_r = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the PLL `locked` flag in the 48 MHz reference domain and produces a clean, delayed reset for logic clocked by the PLL outputs (e.g. the 100 MHz counter domain). Synchronizes the asynchronous `locked`, requires it to stay high for a programmable stabilization window before releasing reset, and counts lock-loss events. It also drives the board RGB LED with a status pattern. It sits between the PLL instance and every block clocked by `clk100`.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `locked`; legal range 2..4.
- `LOCK_CYCLES`, 4800: consecutive synchronized-high cycles required before release (100 µs at 48 MHz); legal range ≥ 2.
- `LOSS_CNT_W`, 8: width of the lock-loss counter.
- `BLINK_DIV`, 24: bit of the free-running blink counter used for the red blink.
- `clk48`  in  1  48 MHz reference clock, free-running regardless of PLL state.
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock flag, asynchronous to `clk48`.
- `clear_count`  in  1  single-cycle pulse; zeroes `loss_count`.
- `domain_rst`  out  1  active-high reset for PLL-clocked logic; consumers re-synchronize its release into their own clock.
- `ready`  out  1  high only in RUN.
- `lock_lost`  out  1  one-cycle pulse on the RUN→UNLOCKED transition.
- `loss_count`  out  LOSS_CNT_W  saturating count of lock losses from RUN.
- `rgb_led0_r`, `rgb_led0_g`, `rgb_led0_b`  out  1 each  active-low status LED.

## Operation
- **Synchronizer:** `locked` passes through a SYNC_STAGES-deep chain. Only the last stage (`locked_s`) is used.
- **States:**
  - UNLOCKED (reset state).
  - STABILIZE.
  - RUN.
- **UNLOCKED:** if `locked_s`=1, go to STABILIZE and set `stab_cnt`=0.
- **STABILIZE:**
  - If `locked_s`=0, go to UNLOCKED. This is not counted as a loss.
  - Else if `stab_cnt`=LOCK_CYCLES-1, go to RUN.
  - Else increment `stab_cnt`.
- **RUN:** if `locked_s`=0, go to UNLOCKED, pulse `lock_lost` for one cycle, and increment `loss_count`.
- **`stab_cnt`:** width is clog2(LOCK_CYCLES). It is reset to 0 on every entry to STABILIZE.
- **`loss_count`:** saturates at all-ones; there is no wrap.
  - `clear_count` sets it to 0.
  - If `clear_count` and a loss occur in the same cycle, `loss_count` becomes 1.
- **Output decodes** (all from registered state):
  - `domain_rst` = (state≠RUN).
  - `ready` = (state=RUN).
- **Blink counter:** free-running, BLINK_DIV bits wide, reset to 0.
- **LED decodes** (0 = lit):
  - UNLOCKED: `rgb_led0_r` = ~blink[BLINK_DIV-1]; green and blue are 1.
  - STABILIZE: `rgb_led0_b`=0; red and green are 1.
  - RUN: `rgb_led0_g`=0; red and blue are 1.
- **Reset values** (while `rst` is high and on the first cycle after):
  - state UNLOCKED; sync chain 0; `stab_cnt` 0; `loss_count` 0; blink counter 0.
  - `domain_rst`=1, `ready`=0, `lock_lost`=0.
  - All LED outputs 1.
- **Reset mid-operation:** `rst` in RUN forces UNLOCKED next cycle, with no `lock_lost` pulse and no loss count. `loss_count` is cleared.

## Timing
- `locked` rising, sampled at edge 0, appears on `locked_s` after SYNC_STAGES edges.
- STABILIZE is entered on the next edge and lasts exactly LOCK_CYCLES cycles.
- `domain_rst` falls SYNC_STAGES+1+LOCK_CYCLES edges after `locked` is first sampled high: 4803 with defaults.
- `locked` falling while in RUN: `domain_rst` rises and `lock_lost` pulses SYNC_STAGES+1 edges after the sample.
- `loss_count` updates on the same edge that `lock_lost` asserts.
- A `locked` glitch narrower than one `clk48` period may be missed. This is acceptable; one that is sampled low is always honoured.
- `locked` low for exactly one sampled cycle during STABILIZE restarts the full window.
- No combinational path from inputs to outputs.

## Test plan
Parameters for all tests: SYNC_STAGES=2, LOCK_CYCLES=16, LOSS_CNT_W=2, BLINK_DIV=4.

- Hold `rst` 3 cycles with `locked`=1, then release.
  - Required: `domain_rst`=1, `ready`=0 and all LEDs 1 during reset.
  - `domain_rst` falls exactly 19 edges after the first post-reset sample.
  - Green is lit from that edge.
- `locked` 0 throughout.
  - Required: `rgb_led0_r` toggles every 8 cycles.
  - `domain_rst` stays 1 and `loss_count` stays 0.
- `locked` high 10 cycles, low 1 cycle, then high.
  - Required: no RUN entry at the 19-edge point.
  - `domain_rst` falls 16 cycles after STABILIZE is re-entered.
  - `loss_count` stays 0.
- Reach RUN, drop `locked`.
  - Required: 3 edges later `lock_lost`=1 for one cycle, `domain_rst`=1, and `loss_count`=1.
- Four lock losses from RUN.
  - Required: `loss_count` reads 1, 2, 3, 3 (saturation).
  - Pulse `clear_count` in the same cycle as the fifth loss: result `loss_count`=1.
- Assert `rst` in RUN.
  - Required: next cycle state is UNLOCKED, `loss_count`=0, and `lock_lost` never pulses.
